uart_rx_param: RTL

Parametrised UART receiver for the RISC-V multi-cycle SoC's UART port. Successor to the fixed 8N1 receiver. Adds:
- configurable data width, parity mode, stop-bit count and bit period;
- per-frame error flags;
- a valid/ready output handshake with optional receive FIFO and sticky overrun.

It sits between the `UART_Rx` pin and the memory-mapped UART peripheral registers.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART receiver.
//   - parity-mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - receiver FSM state encoding
//   - entry_width(): width of one buffered entry {frame_err, parity_err, data}
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop,
      StWaitHi
   } rx_state_e;

   function automatic int unsigned entry_width(input int unsigned data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO for uart_rx_param (used only with UART_RX_FIFO_EN).
// Pointers carry one extra wrap bit to tell full from empty. Head entry is read
// combinationally from storage.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, wdata_i   write request and entry; ignored when full unless popping
//   pop_i             remove head entry (ignored when empty)
//   rdata_o           head entry
//   empty_o, full_o   occupancy flags
module uart_rx_fifo #(
   parameter int unsigned Width = 10,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
   logic [Width-1:0] mem_q [Depth];
   logic             wr_en, rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign rd_en   = pop_i && !empty_o;
   // A pop in the same cycle frees the slot that the write lands in.
   assign wr_en   = push_i && (!full_o || rd_en);
   assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
            wr_ptr_q                   <= wr_ptr_q + 1'b1;
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with per-frame error flags,
// valid/ready output handshake and sticky overrun.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO;
// otherwise a single holding register buffers one frame.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rx                        serial input (asynchronous, idles high)
//   rx_data                   head word
//   rx_frame_err              head word had a low stop bit
//   rx_parity_err             head word failed parity check
//   rx_valid, rx_ready        output handshake
//   overrun, clr_overrun      sticky drop flag and its synchronous clear
//   busy                      frame in progress
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DIV        = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   input  logic                 clr_overrun,
   output logic                 busy
);

   localparam int unsigned EntryW = entry_width(DATA_BITS);
   localparam int unsigned CntW   = $clog2(DIV);
   localparam int unsigned BitW   = 4;
   localparam logic [CntW-1:0] HalfCnt = CntW'(DIV / 2 - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DIV - 1);

   if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_rx_param: illegal parameter value");
   end

   logic                 rx_meta_q, rxs_q;
   rx_state_e            state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 acc_q, acc_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 tick, push, pop, drop, stop_ferr;
   logic [EntryW-1:0]    push_entry, head;
   logic                 overrun_q;

   assign tick       = (cnt_q == '0);
   assign stop_ferr  = ferr_q | ~rxs_q;
   assign push_entry = {stop_ferr, perr_q, shreg_q};

   // State register, synchroniser and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         acc_q     <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         acc_q     <= acc_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
      end
   end

   // Next-state logic. bit_q counts data bits in StData and stop bits in StStop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      acc_d   = acc_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxs_q) begin
               state_d = StStart;
               cnt_d   = HalfCnt;
            end
         end
         StStart: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs_q) begin
               state_d = StIdle;
            end else begin
               state_d = StData;
               cnt_d   = FullCnt;
               bit_d   = '0;
               acc_d   = 1'b0;
               ferr_d  = 1'b0;
               perr_d  = 1'b0;
            end
         end
         StData: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
               acc_d   = acc_q ^ rxs_q;
               cnt_d   = FullCnt;
               if (bit_q == BitW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? StPar : StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StPar: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Odd mode needs XOR = 1, even mode needs XOR = 0.
               perr_d  = (acc_q ^ rxs_q) ^ (PARITY == PAR_ODD);
               cnt_d   = FullCnt;
               state_d = StStop;
            end
         end
         StStop: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ferr_d = stop_ferr;
               cnt_d  = FullCnt;
               if (bit_q == BitW'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  bit_d   = '0;
                  state_d = stop_ferr ? StWaitHi : StIdle;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StWaitHi: begin
            if (rxs_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q != StIdle);
   end

`ifdef UART_RX_FIFO_EN
   logic fifo_empty, fifo_full;

   assign pop      = !fifo_empty && rx_ready;
   assign drop     = push && fifo_full && !pop;
   assign rx_valid = !fifo_empty;

   uart_rx_fifo #(
      .Width (EntryW),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );
`else
   logic              hold_valid_q;
   logic [EntryW-1:0] hold_q;

   assign pop      = hold_valid_q && rx_ready;
   assign drop     = push && hold_valid_q && !pop;
   assign rx_valid = hold_valid_q;
   assign head     = hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else if (push && !drop) begin
         hold_valid_q <= 1'b1;
         hold_q       <= push_entry;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end
`endif

   // Set wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              overrun_q <= 1'b0;
      else if (drop)        overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
   end

   assign overrun       = overrun_q;
   assign rx_data       = head[DATA_BITS-1:0];
   assign rx_parity_err = head[DATA_BITS];
   assign rx_frame_err  = head[DATA_BITS+1];

endmodule
